// File: rtl/paddle_input_ctrl.sv
// Synchronises, debounces and edge-detects the two paddle buttons and drives a saturating
// paddle position. Define PADDLE_AUTOREPEAT_EN to enable hold-to-repeat stepping.
module paddle_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned POS_W           = 10,
    parameter int unsigned POS_INIT        = 100,
    parameter int unsigned POS_MIN         = 60,
    parameter int unsigned POS_MAX         = 420,
    parameter int unsigned STEP            = 42,
    parameter int unsigned REPEAT_DELAY    = 30000000,
    parameter int unsigned REPEAT_RATE     = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       btn,
    output logic [1:0]       btn_db,
    output logic [POS_W-1:0] paddle_pos,
    output logic             move_up,
    output logic             move_dn,
    output logic             at_limit
);

    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [POS_W:0] PosMin = (POS_W + 1)'(POS_MIN);
    localparam logic [POS_W:0] PosMax = (POS_W + 1)'(POS_MAX);
    localparam logic [POS_W:0] Step   = (POS_W + 1)'(STEP);

    logic [1:0]       s1_q, s2_q;
    logic [DbW-1:0]   db_cnt_q [2];
    logic [1:0]       btn_db_q, btn_db_dly_q, press_q;
    logic [1:0]       tick;
    logic [POS_W-1:0] pos_q;
    logic             move_up_q, move_dn_q, at_limit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            btn_db_q     <= '0;
            btn_db_dly_q <= '0;
            press_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            s1_q         <= btn;
            s2_q         <= s1_q;
            btn_db_dly_q <= btn_db_q;
            press_q      <= btn_db_q & ~btn_db_dly_q;
            for (int i = 0; i < 2; i++) begin
                // Any return to the current level restarts the stability window.
                if (s2_q[i] != btn_db_q[i]) begin
                    if (db_cnt_q[i] == DbLast) begin
                        btn_db_q[i] <= s2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

`ifdef PADDLE_AUTOREPEAT_EN
    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_e;

    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;
    localparam logic [RptW-1:0] DelayLast = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] RateLast  = RptW'(REPEAT_RATE - 1);

    rpt_state_e      rpt_state_q [2];
    logic [RptW-1:0] rcnt_q      [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rpt_state_q[i] <= StIdle;
                rcnt_q[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!btn_db_q[i]) begin
                    rpt_state_q[i] <= StIdle;
                    rcnt_q[i]      <= '0;
                end else begin
                    unique case (rpt_state_q[i])
                        StIdle: begin
                            if (press_q[i]) begin
                                rpt_state_q[i] <= StDelay;
                                rcnt_q[i]      <= '0;
                            end
                        end
                        StDelay: begin
                            if (rcnt_q[i] == DelayLast) begin
                                rpt_state_q[i] <= StRepeat;
                                rcnt_q[i]      <= '0;
                            end else begin
                                rcnt_q[i] <= rcnt_q[i] + RptW'(1);
                            end
                        end
                        StRepeat: begin
                            if (rcnt_q[i] == RateLast) begin
                                rcnt_q[i] <= '0;
                            end else begin
                                rcnt_q[i] <= rcnt_q[i] + RptW'(1);
                            end
                        end
                        default: begin
                            rpt_state_q[i] <= StIdle;
                            rcnt_q[i]      <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // A tick is suppressed on the cycle the debounced level drops.
    always_comb begin
        tick = '0;
        for (int i = 0; i < 2; i++) begin
            if (btn_db_q[i]) begin
                unique case (rpt_state_q[i])
                    StDelay:  tick[i] = (rcnt_q[i] == DelayLast);
                    StRepeat: tick[i] = (rcnt_q[i] == RateLast);
                    default:  tick[i] = 1'b0;
                endcase
            end
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE};
    assign tick = '0;
`endif

    logic           up_req, dn_req;
    logic [POS_W:0] pos_ext, up_sum, dn_val, pos_nxt;

    always_comb begin
        up_req  = press_q[1] | tick[1];
        dn_req  = press_q[0] | tick[0];
        pos_ext = {1'b0, pos_q};
        up_sum  = pos_ext + Step;
        dn_val  = (pos_ext > Step) ? (pos_ext - Step) : '0;
        pos_nxt = pos_ext;
        if (up_req && !dn_req) begin
            pos_nxt = (up_sum > PosMax) ? PosMax : up_sum;
        end else if (dn_req && !up_req) begin
            pos_nxt = (dn_val < PosMin) ? PosMin : dn_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q      <= POS_W'(POS_INIT);
            move_up_q  <= 1'b0;
            move_dn_q  <= 1'b0;
            at_limit_q <= (POS_INIT == POS_MIN) || (POS_INIT == POS_MAX);
        end else begin
            pos_q      <= pos_nxt[POS_W-1:0];
            move_up_q  <= up_req && !dn_req && (pos_nxt != pos_ext);
            move_dn_q  <= dn_req && !up_req && (pos_nxt != pos_ext);
            at_limit_q <= (pos_nxt == PosMin) || (pos_nxt == PosMax);
        end
    end

    assign btn_db     = btn_db_q;
    assign paddle_pos = pos_q;
    assign move_up    = move_up_q;
    assign move_dn    = move_dn_q;
    assign at_limit   = at_limit_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed bench for paddle_input_ctrl: expected steps are queued when buttons are driven
// and checked by a monitor when the paddle moves. Auto-repeat checks need PADDLE_AUTOREPEAT_EN.
module tb_paddle_input_ctrl;

    localparam int Lat = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn = 2'b00;
    logic [1:0] btn_db;
    logic [9:0] paddle_pos;
    logic       move_up, move_dn, at_limit;

    paddle_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .POS_W          (10),
        .POS_INIT       (100),
        .POS_MIN        (60),
        .POS_MAX        (420),
        .STEP           (42),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .btn_db    (btn_db),
        .paddle_pos(paddle_pos),
        .move_up   (move_up),
        .move_dn   (move_dn),
        .at_limit  (at_limit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at_edge;
        logic [9:0] pos;
        logic       up;
        logic       dn;
        logic       lim;
    } exp_t;

    exp_t sb[$];
    int   ncomp = 0;
    int   nfail = 0;
    int   model_pos = 100;
    int   prev_pos = 100;

    task automatic chk(input string tag, input int got, input int want);
        ncomp++;
        assert (got === want) else begin
            nfail++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Queue the step a request at edge at_e should produce, if the position actually changes.
    task automatic expect_step(input logic up, input int at_e);
        int   np;
        exp_t e;
        if (up) np = (model_pos + 42 > 420) ? 420 : model_pos + 42;
        else    np = (model_pos - 42 < 60) ? 60 : model_pos - 42;
        if (np != model_pos) begin
            e.at_edge = at_e;
            e.pos     = 10'(np);
            e.up      = up;
            e.dn      = !up;
            e.lim     = (np == 60) || (np == 420);
            sb.push_back(e);
            model_pos = np;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_pos = int'(paddle_pos);
        end else if (move_up || move_dn || int'(paddle_pos) != prev_pos) begin
            chk("step_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("step_edge", cyc, e.at_edge);
                chk("step_pos", int'(paddle_pos), int'(e.pos));
                chk("step_flags", int'({move_up, move_dn, at_limit}),
                    int'({e.up, e.dn, e.lim}));
            end
            prev_pos = int'(paddle_pos);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        btn = 2'b00;
        sb.delete();
        model_pos = 100;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_btn_db", int'(btn_db), 0);
        chk("reset_pos", int'(paddle_pos), 100);
        chk("reset_flags", int'({move_up, move_dn, at_limit}), 0);
    endtask

    // Drive a clean press of pattern b, hold it for hold edges, then release and settle.
    task automatic press(input logic [1:0] b, input int hold);
        @(posedge clk);
        #1 btn = b;
        if (b == 2'b10) expect_step(1'b1, cyc + Lat);
        if (b == 2'b01) expect_step(1'b0, cyc + Lat);
        repeat (hold) @(posedge clk);
        #1 chk("btn_db_held", int'(btn_db), int'(b));
        btn = 2'b00;
        repeat (12) @(posedge clk);
        #1 chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        bit db_seen;
        int n0;

        // Single up press, exact latency.
        do_reset();
        press(2'b10, 9);
        chk("t1_pos", int'(paddle_pos), 142);
        chk("t1_limit", int'(at_limit), 0);

        // Short glitch on down button never reaches btn_db.
        do_reset();
        @(posedge clk);
        #1 btn = 2'b01;
        repeat (3) @(posedge clk);
        #1 btn = 2'b00;
        db_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (btn_db != 2'b00) db_seen = 1'b1;
        end
        chk("t2_glitch_db", int'(db_seen), 0);
        chk("t2_pos", int'(paddle_pos), 100);

        // Walk up into the top limit, then step back down.
        do_reset();
        repeat (9) press(2'b10, 9);
        chk("t3_pos_sat", int'(paddle_pos), 420);
        chk("t3_limit_sat", int'(at_limit), 1);
        press(2'b01, 9);
        chk("t3_pos_back", int'(paddle_pos), 378);
        chk("t3_limit_back", int'(at_limit), 0);

        // Down into the bottom limit, then a saturated press.
        do_reset();
        press(2'b01, 9);
        chk("t4_pos_min", int'(paddle_pos), 60);
        chk("t4_limit", int'(at_limit), 1);
        press(2'b01, 9);
        chk("t4_pos_still", int'(paddle_pos), 60);

        // Both buttons together cancel.
        press(2'b11, 9);
        chk("t5_pos", int'(paddle_pos), 60);
        press(2'b11, 9);
        chk("t5_pos_again", int'(paddle_pos), 60);

`ifdef PADDLE_AUTOREPEAT_EN
        // Hold until the debounced level has been high 30 cycles past the press event.
        do_reset();
        @(posedge clk);
        #1 btn = 2'b10;
        n0 = cyc;
        expect_step(1'b1, n0 + 8);
        expect_step(1'b1, n0 + 18);
        expect_step(1'b1, n0 + 23);
        expect_step(1'b1, n0 + 28);
        expect_step(1'b1, n0 + 33);
        repeat (31) @(posedge clk);
        #1 btn = 2'b00;
        repeat (25) @(posedge clk);
        #1 chk("t6_sb_drained", sb.size(), 0);
        chk("t6_pos", int'(paddle_pos), 310);

        // Reset in the middle of a hold abandons everything.
        @(posedge clk);
        #1 btn = 2'b10;
        expect_step(1'b1, cyc + Lat);
        repeat (14) @(posedge clk);
        #1 chk("t6_mid_pos", int'(paddle_pos), 352);
        do_reset();
        repeat (40) @(posedge clk);
        #1 chk("t6_post_reset_pos", int'(paddle_pos), 100);
        chk("t6_post_reset_sb", sb.size(), 0);
`else
        n0 = 0;
        // Without auto-repeat a long hold gives exactly one step.
        do_reset();
        press(2'b10, 60);
        chk("t6_single_step", int'(paddle_pos), 142 + n0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
